shift_right_seq: RTL and testbench
==================================

SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 Clock  input  1  single clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 Start  input  1  request pulse; sampled only in IDLE.
REQ-004 A  input  24  operand to be shifted right.
REQ-005 B  input  24  register-sourced shift amount, unsigned.
REQ-006 SHAMT  input  4  immediate shift amount, unsigned, zero-extended.
REQ-007 Arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); sampled with Start.
REQ-008 Busy  output  1  high whenever state is not IDLE.
REQ-009 Done  output  1  single-cycle pulse when Result becomes valid.
REQ-010 Result  output  24  shifted value, held stable from the Done cycle until the next accepted Start.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-012 In IDLE with Start=1, the block SHALL latch A, Arith and N = min(B + SHAMT, 24), where the sum is formed 25 bits wide and any carry-out forces N=24.
REQ-013 On acceptance, the block SHALL go to SHIFT if N>0; otherwise it SHALL go to DONE with A unmodified.
REQ-014 Each SHIFT cycle SHALL shift the working value right by k = min(remaining, 4) and decrement remaining by k.
REQ-015 The block SHALL go to DONE in the cycle in which remaining reaches 0.
REQ-016 Vacated bits SHALL be 0 when Arith=0 and copies of the latched A[23] when Arith=1.
REQ-017 With Start accepted in cycle 0, Done SHALL assert in cycle ceil(N/4)+1: N=0 -> cycle 1, N=24 -> cycle 7.
REQ-018 DONE SHALL last exactly one cycle with Done=1 and SHALL then return to IDLE.
REQ-019 Start SHALL be ignored while Busy=1, including in the DONE cycle.
REQ-020 A Start sampled in the IDLE cycle that follows DONE SHALL be accepted (back-to-back operation).
REQ-021 Result SHALL change only on the DONE transition and SHALL NOT expose intermediate SHIFT values.

Reset
REQ-022 Asserting Reset SHALL force IDLE, Result=24'd0, Done=0, Busy=0 and clear all latched operands, regardless of state.
REQ-023 Reset asserted during SHIFT SHALL abort the operation without a Done pulse.
REQ-024 The first Start after Reset deasserts SHALL be accepted normally.

Configuration
REQ-025 The macro SHIFT_RIGHT_ARITH_EN SHALL control arithmetic-shift support.
REQ-026 With SHIFT_RIGHT_ARITH_EN defined, the Arith input SHALL behave as specified in REQ-016.
REQ-027 Without SHIFT_RIGHT_ARITH_EN, the Arith port SHALL remain present but be ignored, and all fills SHALL be 0.

Structure
REQ-028 A shared package SHALL hold the data width (24), the maximum step per cycle (4), the shift-amount clamp (24) and the state encoding.
REQ-029 One combinational sub-module, shift_right_step, SHALL perform a right shift of 0-4 bits with a fill-bit input; the FSM and registers SHALL remain in shift_right_seq.

Verification
REQ-030 A=0x800001, B=0, SHAMT=4, Arith=0 -> Result=0x080000, Done in cycle 2.
REQ-031 The same operands with Arith=1 and the macro defined -> Result=0xF80000; with the macro undefined -> 0x080000.
REQ-032 A=0x800000, B=20, SHAMT=4, Arith=1 -> Result=0xFFFFFF, Done in cycle 7; with Arith=0 -> Result=0x000000.
REQ-033 B=0xFFFFFF, SHAMT=1 (carry-out), A=0x123456, Arith=0 -> N clamped to 24, Result=0x000000; B=0, SHAMT=0 -> Result=0x123456, Done in cycle 1.
REQ-034 Start again in cycles 1-3 of an N=12 operation -> extra Starts ignored, exactly one Done in cycle 4.
REQ-035 Reset pulsed during SHIFT -> Busy=0, Result=0, no Done; a following Start with A=0x00F000, N=8 -> Result=0x0000F0.

Source files
------------

// File: rtl/shift_right_seq_pkg.sv
// Shared widths, limits and state encoding for the sequential right shifter.
package shift_right_seq_pkg;

    localparam int DATA_W    = 24;
    localparam int SHAMT_W   = 4;
    localparam int STEP_MAX  = 4;
    localparam int SHAMT_MAX = 24;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 25-bit sum so a carry out of B+SHAMT still clamps to the full width.
    function automatic logic [CNT_W-1:0] clamp_amount(input logic [DATA_W-1:0]  b,
                                                      input logic [SHAMT_W-1:0] shamt);
        logic [DATA_W:0] sum;
        sum = {1'b0, b} + {{(DATA_W + 1 - SHAMT_W){1'b0}}, shamt};
        if (sum > (DATA_W + 1)'(SHAMT_MAX))
            return CNT_W'(SHAMT_MAX);
        else
            return sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/shift_right_seq_step.sv
// Combinational right shift by 0-4 bits, vacated positions taken from fill.
module shift_right_step
    import shift_right_seq_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    input  logic [2:0]        k,
    input  logic              fill,
    output logic [DATA_W-1:0] dout
);

    logic signed [DATA_W:0] ext;
    logic signed [DATA_W:0] shifted;

    // Prepending the fill bit lets a signed shift replicate it into the top.
    always_comb begin
        ext     = {fill, din};
        shifted = ext >>> k;
        dout    = shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter, up to 4 bit positions per cycle.
// Arithmetic (sign-fill) mode is enabled by defining SHIFT_RIGHT_ARITH_EN.
module shift_right_seq
    import shift_right_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        shamt,
    input  logic              arith,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] work;
    logic [CNT_W-1:0]  remaining;
    logic              fill;

    logic [CNT_W-1:0]  n_req;
    logic              fill_req;
    logic [2:0]        k;
    logic [DATA_W-1:0] step_out;
    logic              last_step;

    assign n_req = clamp_amount(b, shamt);

`ifdef SHIFT_RIGHT_ARITH_EN
    assign fill_req = arith & a[DATA_W-1];
`else
    logic unused_arith;
    assign unused_arith = arith;
    assign fill_req     = 1'b0;
`endif

    assign k         = (remaining >= CNT_W'(STEP_MAX)) ? 3'(STEP_MAX) : remaining[2:0];
    assign last_step = (remaining == {2'b00, k});

    shift_right_step u_step (
        .din  (work),
        .k    (k),
        .fill (fill),
        .dout (step_out)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (n_req == '0) ? DONE : SHIFT;
            SHIFT:   if (last_step) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // result only loads on entry to DONE so intermediate steps never show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            remaining <= '0;
            fill      <= 1'b0;
            result    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        work      <= a;
                        remaining <= n_req;
                        fill      <= fill_req;
                        if (n_req == '0)
                            result <= a;
                    end
                end
                SHIFT: begin
                    work      <= step_out;
                    remaining <= remaining - {2'b00, k};
                    if (last_step)
                        result <= step_out;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq with a behavioural shift model.
module tb_shift_right_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] a;
    logic [23:0] b;
    logic [3:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [23:0] result;

    shift_right_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .shamt  (shamt),
        .arith  (arith),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] res;
        int          done_cyc;
    } exp_t;

    exp_t        sbq[$];
    int          cyc         = 0;
    int          checks      = 0;
    int          errors      = 0;
    int          last_accept = -10;
    int          last_done   = -10;
    int          next_idle   = 0;
    logic [23:0] exp_hold    = '0;

    function automatic int amount(input logic [23:0] ib, input logic [3:0] ish);
        int s;
        s = int'(ib) + int'(ish);
        return (s > 24) ? 24 : s;
    endfunction

    function automatic logic [23:0] ref_shift(input logic [23:0] ia, input int n, input bit iar);
        logic signed [23:0] sa;
        bit eff;
`ifdef SHIFT_RIGHT_ARITH_EN
        eff = iar;
`else
        eff = 1'b0;
        if (iar) eff = 1'b0;
`endif
        if (eff) begin
            sa = ia;
            sa = sa >>> n;
            return sa;
        end
        return ia >> n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: owns the cycle count and compares every cycle against the model.
    initial begin
        bit exp_busy;
        bit exp_done;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            exp_busy = (cyc > last_accept) && (cyc <= last_done);
            exp_done = (sbq.size() > 0) && (sbq[0].done_cyc == cyc);
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                exp_hold = sbq[0].res;
                void'(sbq.pop_front());
            end
            chk("result", 32'(result), 32'(exp_hold));
        end
    end

    task automatic drive(input bit s, input logic [23:0] ia, input logic [23:0] ib,
                         input logic [3:0] ish, input bit iar);
        int   n;
        int   lat;
        exp_t e;
        @(negedge clk);
        start = s;
        a     = ia;
        b     = ib;
        shamt = ish;
        arith = iar;
        if (s && cyc >= next_idle) begin
            n          = amount(ib, ish);
            lat        = (n + 3) / 4 + 1;
            e.res      = ref_shift(ia, n, iar);
            e.done_cyc = cyc + lat;
            sbq.push_back(e);
            last_accept = cyc;
            last_done   = cyc + lat;
            next_idle   = last_done + 1;
        end
    endtask

    task automatic run_op(input logic [23:0] ia, input logic [23:0] ib,
                          input logic [3:0] ish, input bit iar);
        for (int i = 0; i < 20 && cyc < next_idle; i++)
            drive(1'b0, '0, '0, '0, 1'b0);
        drive(1'b1, ia, ib, ish, iar);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        sbq.delete();
        last_accept = -10;
        last_done   = -10;
        next_idle   = 0;
        exp_hold    = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        shamt = '0;
        arith = 1'b0;
        #1;
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_result", 32'(result), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(24'h800001, 24'd0, 4'd4, 1'b0);
        run_op(24'h800001, 24'd0, 4'd4, 1'b1);
        run_op(24'h800000, 24'd20, 4'd4, 1'b1);
        run_op(24'h800000, 24'd20, 4'd4, 1'b0);
        run_op(24'h123456, 24'hFFFFFF, 4'd1, 1'b0);
        run_op(24'h123456, 24'd0, 4'd0, 1'b0);
        run_op(24'h123456, 24'd0, 4'd0, 1'b1);

        // Restarts while busy must be ignored.
        run_op(24'hA5A5A5, 24'd12, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 24'h00FFFF, 24'd1, 4'd1, 1'b0);

        // Abort mid-shift, then a fresh operation.
        run_op(24'hFFFFFF, 24'd20, 4'd4, 1'b1);
        drive(1'b0, '0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0);
        do_reset();
        drive(1'b0, '0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0);
        run_op(24'h00F000, 24'd5, 4'd3, 1'b0);

        for (int i = 0; i < 600; i++) begin
            logic [23:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'($urandom_range(0, 24));
            drive(bit'($urandom_range(0, 3) != 0), 24'($urandom), rb,
                  4'($urandom), bit'($urandom_range(0, 1)));
        end
        drive(1'b0, '0, '0, '0, 1'b0);

        for (int i = 0; i < 20 && sbq.size() > 0; i++)
            @(posedge clk);
        @(negedge clk);
        chk("drain_pending", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
